// File: rtl/uart_tx_core.sv
// UART transmitter with an input FIFO: words are queued, then framed as
// start / LSB-first data / optional parity / stop bits on a registered tx line.
module uart_tx_core #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tx_valid,
  input  logic [DATA_BITS-1:0]          tx_data,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [AW:0]   FIFO_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_core: DATA_BITS must be 5..9");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx_core: CLKS_PER_BIT must be >= 2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_core: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_core: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
    $error("uart_tx_core: FIFO_DEPTH must be a power of 2, >= 2");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  // ---------------------------------------------------------------- FIFO
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [AW:0]          count_q;
  logic                 push, pop, fifo_empty;

  assign tx_ready   = (count_q != FIFO_FULL);
  assign fifo_empty = (count_q == '0);
  assign push       = tx_valid && tx_ready;
  assign fifo_count = count_q;

  // NOTE: the storage array is deliberately not reset; pointers and count alone
  // decide which entries are valid, so clearing it would only cost flops.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

  // Pointers are AW bits wide, so the +1 wraps modulo FIFO_DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // ----------------------------------------------------------- framer FSM
  state_e               state_q, state_d;
  logic [CW-1:0]        clk_cnt_q, clk_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 bit_done;
  logic [DATA_BITS-1:0] head_word;

  assign bit_done  = (clk_cnt_q == CLK_LAST);
  assign head_word = mem_q[rd_ptr_q];

  // NOTE: every signal driven here gets a default before the case statement,
  // so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    par_d     = par_q;
    bit_cnt_d = bit_cnt_q;
    clk_cnt_d = (state_q == ST_IDLE || bit_done) ? '0 : clk_cnt_q + 1'b1;
    pop       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) pop = 1'b1;
      end
      ST_START: begin
        if (bit_done) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_done) begin
          state_d   = ST_STOP;
          bit_cnt_d = '0;
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          if (bit_cnt_q == STOP_LAST) begin
            if (!fifo_empty) pop = 1'b1;
            else             state_d = ST_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Loading a word always restarts a frame, from IDLE or straight out of STOP.
    if (pop) begin
      shift_d   = head_word;
      par_d     = (PARITY == 2) ? ^head_word : ~^head_word;
      state_d   = ST_START;
      clk_cnt_d = '0;
      bit_cnt_d = '0;
    end

    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      tx_q      <= tx_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx_core.sv
// Self-checking bench for uart_tx_core: three parameterisations, a frame-level
// line model, directed corner sequences and a randomized UART-receiver scoreboard.
module tb_uart_tx_core;

  localparam int CPB = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // A: defaults with even parity; B: odd parity, 2 stops; C: 7 data bits, no parity.
  logic       valid_a = 1'b0, valid_b = 1'b0, valid_c = 1'b0;
  logic [7:0] data_a = '0, data_b = '0;
  logic [6:0] data_c = '0;
  logic       ready_a, ready_b, ready_c;
  logic       tx_a, tx_b, tx_c;
  logic       busy_a, busy_b, busy_c;
  logic [2:0] cnt_a, cnt_b, cnt_c;

  uart_tx_core #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .rst(rst), .tx_valid(valid_a), .tx_data(data_a), .tx_ready(ready_a),
    .tx(tx_a), .tx_busy(busy_a), .fifo_count(cnt_a));

  uart_tx_core #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .rst(rst), .tx_valid(valid_b), .tx_data(data_b), .tx_ready(ready_b),
    .tx(tx_b), .tx_busy(busy_b), .fifo_count(cnt_b));

  uart_tx_core #(.DATA_BITS(7), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_c (
    .clk(clk), .rst(rst), .tx_valid(valid_c), .tx_data(data_c), .tx_ready(ready_c),
    .tx(tx_c), .tx_busy(busy_c), .fifo_count(cnt_c));

  int tests_run    = 0;
  int tests_failed = 0;

  logic [8:0] line_q [$];
  logic [8:0] sb_q   [$];
  bit         drv_done = 1'b0;
  int         n_acc = 0, n_dec = 0;

  typedef struct {
    int         inst;
    logic [8:0] word;
    int         exp_len;
    logic       exp_par;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic get_tx(input int i);
    case (i)
      0:       return tx_a;
      1:       return tx_b;
      default: return tx_c;
    endcase
  endfunction

  function automatic logic get_busy(input int i);
    case (i)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  function automatic logic get_ready(input int i);
    case (i)
      0:       return ready_a;
      1:       return ready_b;
      default: return ready_c;
    endcase
  endfunction

  function automatic logic [2:0] get_cnt(input int i);
    case (i)
      0:       return cnt_a;
      1:       return cnt_b;
      default: return cnt_c;
    endcase
  endfunction

  function automatic int dbits(input int i);
    return (i == 2) ? 7 : 8;
  endfunction

  function automatic int par_mode(input int i);
    case (i)
      0:       return 2;
      1:       return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int stops(input int i);
    return (i == 1) ? 2 : 1;
  endfunction

  // Value of serial bit k of the frame carrying word w on instance i.
  function automatic logic line_bit(input int i, input logic [8:0] w, input int k);
    logic x;
    x = 1'b0;
    if (k == 0) return 1'b0;
    if (k <= dbits(i)) return w[k-1];
    if (par_mode(i) != 0 && k == dbits(i) + 1) begin
      for (int j = 0; j < dbits(i); j++) x ^= w[j];
      return (par_mode(i) == 2) ? x : ~x;
    end
    return 1'b1;
  endfunction

  function automatic int frame_len(input int i);
    return (1 + dbits(i) + ((par_mode(i) != 0) ? 1 : 0) + stops(i)) * CPB;
  endfunction

  task automatic drive(input int i, input logic v, input logic [8:0] w);
    case (i)
      0:       begin valid_a = v; data_a = w[7:0]; end
      1:       begin valid_b = v; data_b = w[7:0]; end
      default: begin valid_c = v; data_c = w[6:0]; end
    endcase
  endtask

  // Called at the negedge holding the first start-bit cycle; checks n
  // contiguous frames from line_q, one comparison per frame.
  task automatic check_line(input int i, input string name, input int n);
    int errs;
    logic [8:0] w;
    for (int f = 0; f < n; f++) begin
      errs = 0;
      w = (f < line_q.size()) ? line_q[f] : 9'h000;
      for (int c = 0; c < frame_len(i); c++) begin
        if (get_tx(i) !== line_bit(i, w, c / CPB)) errs++;
        if (get_busy(i) !== 1'b1) errs++;
        @(negedge clk);
      end
      check($sformatf("%s frame %0d", name, f), errs, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         errs;
    int         c;
    logic       par;
    int         i;
    int         n;
    logic [8:0] word;

    vecs[0] = '{0, 9'h0A5, 88, 1'b0};
    vecs[1] = '{0, 9'h001, 88, 1'b1};
    vecs[2] = '{0, 9'h0FF, 88, 1'b0};
    vecs[3] = '{1, 9'h000, 96, 1'b1};
    vecs[4] = '{1, 9'h007, 96, 1'b0};
    vecs[5] = '{2, 9'h07F, 72, 1'b0};
    vecs[6] = '{2, 9'h055, 72, 1'b0};

    // ---- reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset tx",     tx_a,    1);
    check("reset busy",   busy_a,  0);
    check("reset ready",  ready_a, 1);
    check("reset count",  cnt_a,   0);
    check("reset tx b",   tx_b,    1);
    check("reset count c", cnt_c,  0);
    rst = 1'b0;

    // ---- reset mid-frame: word 0x00 sending, two more queued, hit data bit 3
    for (int t = 0; t <= 36; t++) begin
      @(negedge clk);
      if (t < 36) begin
        case (t)
          0:       drive(0, 1'b1, 9'h000);
          2:       drive(0, 1'b1, 9'h05A);
          3:       drive(0, 1'b1, 9'h03C);
          default: drive(0, 1'b0, 9'h000);
        endcase
      end
    end
    check("pre-reset tx low",   tx_a,  0);
    check("pre-reset count",    cnt_a, 2);
    rst = 1'b1;
    #1;
    check("mid-reset tx",    tx_a,    1);
    check("mid-reset count", cnt_a,   0);
    check("mid-reset busy",  busy_a,  0);
    check("mid-reset ready", ready_a, 1);
    @(negedge clk);
    rst = 1'b0;
    errs = 0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || busy_a !== 1'b0) errs++;
    end
    check("post-reset line quiet", errs, 0);

    // ---- table-driven single frames (first one is the first push after reset)
    for (int v = 0; v < 7; v++) begin
      i = vecs[v].inst;
      @(negedge clk);
      drive(i, 1'b1, vecs[v].word);
      check($sformatf("vec%0d ready", v), get_ready(i), 1);
      @(negedge clk);
      drive(i, 1'b0, 9'h000);
      check($sformatf("vec%0d tx before start", v), get_tx(i), 1);
      check($sformatf("vec%0d count after push", v), get_cnt(i), 1);
      @(negedge clk);
      c    = 0;
      errs = 0;
      par  = 1'bx;
      while (get_busy(i) && c < 500) begin
        if (c < vecs[v].exp_len && get_tx(i) !== line_bit(i, vecs[v].word, c / CPB)) errs++;
        if (par_mode(i) != 0 && c == (1 + dbits(i)) * CPB + CPB / 2) par = get_tx(i);
        c++;
        @(negedge clk);
      end
      check($sformatf("vec%0d frame bits", v), errs, 0);
      check($sformatf("vec%0d frame length", v), c, vecs[v].exp_len);
      check($sformatf("vec%0d idle tx", v), get_tx(i), 1);
      if (par_mode(i) != 0) check($sformatf("vec%0d parity bit", v), par, vecs[v].exp_par);
    end

    // ---- back-to-back: hold valid with 0x01..0x06
    line_q.delete();
    n    = 0;
    word = 9'h001;
    fork
      begin
        for (int t = 0; t < 10; t++) begin
          @(negedge clk);
          drive(0, 1'b1, word);
          if (ready_a) begin
            line_q.push_back(word);
            n++;
            if (word < 9'h006) word = word + 9'h001;
          end
        end
        check("b2b accepted", n, 5);
        check("b2b count full", cnt_a, 4);
        check("b2b ready low", ready_a, 0);
        drive(0, 1'b0, 9'h000);
      end
      begin
        repeat (3) @(negedge clk);
        check_line(0, "b2b", 5);
      end
    join
    check("b2b idle busy", busy_a, 0);
    check("b2b idle tx",   tx_a,   1);

    // ---- push on the same edge as a pop with two words queued
    line_q.delete();
    line_q.push_back(9'h0C3);
    line_q.push_back(9'h01E);
    line_q.push_back(9'h0B4);
    line_q.push_back(9'h069);
    fork
      begin
        for (int t = 0; t <= 90; t++) begin
          @(negedge clk);
          if (t == 89) check("pushpop count before", cnt_a, 2);
          if (t == 90) check("pushpop count after",  cnt_a, 2);
          case (t)
            0:       drive(0, 1'b1, line_q[0]);
            2:       drive(0, 1'b1, line_q[1]);
            3:       drive(0, 1'b1, line_q[2]);
            89:      drive(0, 1'b1, line_q[3]);
            default: drive(0, 1'b0, 9'h000);
          endcase
        end
      end
      begin
        repeat (3) @(negedge clk);
        check_line(0, "pushpop", 4);
      end
    join
    check("pushpop idle busy", busy_a, 0);

    // ---- randomized traffic against a UART-receiver scoreboard
    fork
      begin
        for (int t = 0; t < 800; t++) begin
          @(negedge clk);
          valid_a = ($urandom_range(0, 3) == 0);
          data_a  = 8'($urandom_range(0, 255));
          if (valid_a && ready_a) begin
            sb_q.push_back({1'b0, data_a});
            n_acc++;
          end
        end
        @(negedge clk);
        valid_a  = 1'b0;
        drv_done = 1'b1;
      end
      begin
        int         budget;
        int         ferr;
        logic [7:0] w;
        logic       p;
        logic [8:0] exp;
        budget = 0;
        while (budget < 20000 && !(drv_done && sb_q.size() == 0 && busy_a == 1'b0)) begin
          @(negedge clk);
          budget++;
          if (tx_a === 1'b0) begin
            ferr = 0;
            repeat (CPB / 2) @(negedge clk);
            if (tx_a !== 1'b0) ferr++;
            for (int b = 0; b < 8; b++) begin
              repeat (CPB) @(negedge clk);
              w[b] = tx_a;
            end
            repeat (CPB) @(negedge clk);
            p = tx_a;
            repeat (CPB) @(negedge clk);
            if (tx_a !== 1'b1) ferr++;
            budget += 10 * CPB + CPB / 2;
            n_dec++;
            if (sb_q.size() == 0) begin
              check("rand frame was queued", 0, 1);
            end else begin
              exp = sb_q.pop_front();
              check("rand word",    {1'b0, w}, exp);
              check("rand parity",  p, line_bit(0, exp, 9));
              check("rand framing", ferr, 0);
            end
          end
        end
        check("rand drained in budget", (budget < 20000), 1);
      end
    join
    check("rand decoded == accepted", n_dec, n_acc);
    check("rand scoreboard empty", sb_q.size(), 0);
    check("rand idle busy", busy_a, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_tx_core.md
UART_TX_CORE -- requirements
Module: uart_tx_core

Interface
REQ-001 Parameter DATA_BITS, default 8, sets the data bits per frame; legal range 5..9.
REQ-002 Parameter CLKS_PER_BIT, default 8, sets the clk cycles per serial bit; legal range >= 2.
REQ-003 Parameter PARITY, default 0, selects parity: 0 none, 1 odd, 2 even.
REQ-004 Parameter STOP_BITS, default 1, sets the stop-bit count; legal values 1 or 2.
REQ-005 Parameter FIFO_DEPTH, default 4, sets the input FIFO entries; power of 2, >= 2.
REQ-006 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-007 Port rst  input  1  asynchronous, active-high reset.
REQ-008 Port tx_valid  input  1  the word on tx_data is offered.
REQ-009 Port tx_data  input  DATA_BITS  word to transmit.
REQ-010 Port tx_ready  output  1  the FIFO can accept a word this cycle.
REQ-011 Port tx  output  1  registered serial line, idle high.
REQ-012 Port tx_busy  output  1  the FIFO is non-empty or a frame is in progress.
REQ-013 Port fifo_count  output  log2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-014 A word SHALL be accepted only on a cycle where tx_valid and tx_ready are both 1 at the clk edge.
REQ-015 tx_ready SHALL equal (fifo_count != FIFO_DEPTH), derived from registered state only.
REQ-016 The FIFO SHALL be first-in first-out, and its pointers SHALL wrap modulo FIFO_DEPTH.
REQ-017 On a simultaneous push and pop, fifo_count SHALL be unchanged.
REQ-018 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP.
REQ-019 In IDLE with the FIFO non-empty, the FSM SHALL pop one word into a shift register and enter START at the same edge.
REQ-020 A word pushed into an empty FIFO while the FSM is IDLE SHALL drive tx low exactly 1 cycle after the accepting edge.
REQ-021 Every bit SHALL be held on tx for exactly CLKS_PER_BIT cycles, timed by a per-bit counter of 0..CLKS_PER_BIT-1.
REQ-022 START SHALL drive tx to 0, then transition to DATA.
REQ-023 DATA SHALL send DATA_BITS bits LSB first, counted by a bit counter, then transition to PARITY if PARITY!=0, else to STOP.
REQ-024 The parity bit SHALL be the XOR of the data bits for even parity and its inverse for odd parity, computed from the popped word.
REQ-025 STOP SHALL drive tx to 1 for STOP_BITS*CLKS_PER_BIT cycles.
REQ-026 At the last STOP cycle, if the FIFO is non-empty, the FSM SHALL pop the next word and enter START with no idle gap; otherwise it SHALL enter IDLE.
REQ-027 The frame length SHALL be (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles.
REQ-028 In IDLE, tx SHALL be 1.
REQ-029 tx_busy SHALL be (state!=IDLE) or (fifo_count!=0).
REQ-030 tx_data and tx_valid SHALL be ignored when tx_ready is 0, and no word SHALL be lost or duplicated.
REQ-031 Illegal parameter values SHALL stop elaboration, via a generate-time check.

Reset
REQ-032 While rst=1, the block SHALL be asynchronously forced to: tx=1, state=IDLE, fifo_count=0, tx_busy=0, tx_ready=1, and all counters and pointers 0.
REQ-033 Reset asserted mid-frame SHALL abort the frame immediately; no bits of that frame or of queued words SHALL appear after release.
REQ-034 The first accepting edge after reset release SHALL behave as in REQ-020.

Verification
REQ-035 Defaults with PARITY=2: push 0xA5 -> tx = 0,1,0,1,0,0,1,0,1,0(parity),1(stop), each held 8 cycles, 88 cycles total, then IDLE and tx_busy=0.
REQ-036 Defaults: hold tx_valid=1 with words 0x01..0x06 -> 5 words accepted, tx_ready drops with fifo_count=4, frames back-to-back with no idle cycle between stop and start.
REQ-037 PARITY=1, STOP_BITS=2: push 0x00 -> parity bit 1, stop high 16 cycles, frame 96 cycles.
REQ-038 DATA_BITS=7, PARITY=0: push 0x7F -> start then 7 ones then stop, 72 cycles.
REQ-039 Assert rst during data bit 3 with 2 words queued -> tx=1 in the same cycle, fifo_count=0, tx_busy=0; after release, tx stays 1 until a new push.
REQ-040 With fifo_count=2, push on the cycle the FSM pops -> fifo_count stays 2, and word order is preserved on tx.
